switch_allocator: RTL and testbench



---
 rtl/switch_allocator_if.sv | 38 +++
 rtl/switch_allocator.sv | 160 ++++++++++++++++
 tb/tb_switch_allocator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_allocator_if.sv
// ---------------------------------------------------------------------------
// switch_allocator_if
// Purpose : bundles the per-port handshake between the input buffers, the
//           switch allocator and the crossbar of a 5-port mesh router.
// Signals : in_valid  [NP]     head flit present at input i
//           in_type   [NP*TW]  head flit type of input i
//           in_req    [NP*NP]  one-hot output request of input i
//           out_ready [NP]     downstream of output o can accept a flit
//           xbar_sel  [NP*NP]  one-hot owning input of output o (0 = free)
//           out_valid [NP]     flit transferred on output o this cycle
//           in_pop    [NP]     head flit of input i consumed this cycle
//           in_err    [NP]     malformed header request on input i
// Modports: slave  - allocator side (consumes requests, drives grants)
//           master - router/buffer side (drives requests, consumes grants)
// ---------------------------------------------------------------------------
interface switch_allocator_if #(
  parameter int NP = 5,
  parameter int TW = 2
);
  logic [NP-1:0]    in_valid;
  logic [NP*TW-1:0] in_type;
  logic [NP*NP-1:0] in_req;
  logic [NP-1:0]    out_ready;
  logic [NP*NP-1:0] xbar_sel;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    in_pop;
  logic [NP-1:0]    in_err;

  modport slave (
    input  in_valid, in_type, in_req, out_ready,
    output xbar_sel, out_valid, in_pop, in_err
  );

  modport master (
    output in_valid, in_type, in_req, out_ready,
    input  xbar_sel, out_valid, in_pop, in_err
  );
endinterface

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
// Purpose : per-output round-robin allocator for a 5-port mesh router
//           (0=Local, 1=East, 2=West, 3=South, 4=North). Each output locks
//           onto one input from header to tail, drives the crossbar select
//           from registered state and pops the input buffer on transfer.
// Ports   : clk   - system clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - switch_allocator_if.slave (requests in, grants out)
// ---------------------------------------------------------------------------
module switch_allocator #(
  parameter int         NP      = 5,
  parameter int         TW      = 2,
  parameter logic [1:0] FT_HDR  = 2'b10,
  parameter logic [1:0] FT_BODY = 2'b00,
  parameter logic [1:0] FT_TAIL = 2'b01,
  parameter logic [1:0] FT_SNGL = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_allocator_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e      state_q [NP];
  state_e      state_d [NP];
  logic [2:0]  owner_q [NP];
  logic [2:0]  owner_d [NP];
  logic [2:0]  rrPtr_q [NP];
  logic [2:0]  rrPtr_d [NP];

  logic [NP-1:0] reqVec  [NP];
  logic [TW-1:0] typeVec [NP];
  logic [NP-1:0] elig    [NP];
  logic [NP-1:0] isHead;
  logic [NP-1:0] isEnd;
  logic [NP-1:0] reqOneHot;
  logic [NP-1:0] inLocked;
  logic [NP-1:0] xfer;
  logic [NP-1:0] xferEnd;

  // Request decode: unpack the flat buses, classify flit types, find which
  // inputs already own an output, and work out per-output eligibility and
  // whether each locked output moves a flit this cycle.
  always_comb begin
    isHead    = '0;
    isEnd     = '0;
    reqOneHot = '0;
    inLocked  = '0;
    xfer      = '0;
    xferEnd   = '0;
    for (int i = 0; i < NP; i++) begin
      reqVec[i]    = bus.in_req[i*NP +: NP];
      typeVec[i]   = bus.in_type[i*TW +: TW];
      isHead[i]    = (typeVec[i] == FT_HDR) || (typeVec[i] == FT_SNGL);
      // Anything that is neither header nor body closes the packet.
      isEnd[i]     = (typeVec[i] != FT_HDR) && (typeVec[i] != FT_BODY);
      reqOneHot[i] = (reqVec[i] != '0) && ((reqVec[i] & (reqVec[i] - 1'b1)) == '0);
    end
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (state_q[o] == LOCKED && owner_q[o] == 3'(i)) begin
          inLocked[i] = 1'b1;
          xfer[o]     = bus.in_valid[i] && bus.out_ready[o] && rst_n;
          xferEnd[o]  = isEnd[i];
        end
      end
    end
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        elig[o][i] = bus.in_valid[i] && isHead[i] && reqOneHot[i] &&
                     reqVec[i][o] && !inLocked[i];
      end
    end
  end

  // State register: reset drops every lock at once and rewinds the
  // round-robin pointers; otherwise take the computed next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 3'd0;
        rrPtr_q[o] <= 3'd0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rrPtr_q[o] <= rrPtr_d[o];
      end
    end
  end

  // Next-state logic: an idle output scans eligible inputs starting at its
  // pointer and wrapping; a locked output releases after moving the last
  // flit of the packet and points just past the input it served.
  always_comb begin
    logic       found;
    logic [3:0] candSum;
    logic [2:0] candIdx;
    found   = 1'b0;
    candSum = 4'd0;
    candIdx = 3'd0;
    for (int o = 0; o < NP; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rrPtr_d[o] = rrPtr_q[o];
      found      = 1'b0;
      case (state_q[o])
        IDLE: begin
          for (int k = 0; k < NP; k++) begin
            candSum = {1'b0, rrPtr_q[o]} + 4'(k);
            if (candSum >= 4'(NP)) candSum = candSum - 4'(NP);
            candIdx = candSum[2:0];
            if (!found && elig[o][candIdx]) begin
              found      = 1'b1;
              state_d[o] = LOCKED;
              owner_d[o] = candIdx;
            end
          end
        end
        LOCKED: begin
          if (xfer[o] && xferEnd[o]) begin
            state_d[o] = IDLE;
            rrPtr_d[o] = (owner_q[o] == 3'(NP-1)) ? 3'd0 : owner_q[o] + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: crossbar select comes straight from the lock registers;
  // transfer and pop strobes follow the owner's valid and downstream ready;
  // malformed headers from unlocked inputs are flagged but never popped.
  always_comb begin
    bus.xbar_sel  = '0;
    bus.out_valid = '0;
    bus.in_pop    = '0;
    bus.in_err    = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (state_q[o] == LOCKED && owner_q[o] == 3'(i)) begin
          bus.xbar_sel[o*NP + i] = 1'b1;
          if (xfer[o]) begin
            bus.out_valid[o] = 1'b1;
            bus.in_pop[i]    = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      bus.in_err[i] = rst_n && bus.in_valid[i] && isHead[i] &&
                      !reqOneHot[i] && !inLocked[i];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
// Purpose : self-checking bench for switch_allocator. A per-output model of
//           busy/owner/pointer tracks expected grants; directed scenarios
//           are followed by randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

  localparam logic [1:0] HDR  = 2'b10;
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b01;
  localparam logic [1:0] SNGL = 2'b11;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  switch_allocator_if bus ();

  switch_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which outputs are busy, who owns them, where the
  // round-robin search starts next time.
  bit mBusy  [5];
  int mOwner [5];
  int mPtr   [5];
  bit modelInit = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit isHeadT(input logic [1:0] t);
    return (t == HDR) || (t == SNGL);
  endfunction

  function automatic bit mLocked(input int i);
    for (int o = 0; o < 5; o++)
      if (mBusy[o] && mOwner[o] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mElig(input int i, input int o, input logic [4:0] v,
                               input logic [9:0] t, input logic [24:0] r);
    return v[i] && isHeadT(t[2*i +: 2]) && r[5*i + o] &&
           ($countones(r[5*i +: 5]) == 1) && !mLocked(i);
  endfunction

  // Expected combinational outputs given current model state and inputs.
  function automatic void modelOutputs(input logic rstn, input logic [4:0] v,
                                       input logic [9:0] t, input logic [24:0] r,
                                       input logic [4:0] rdy,
                                       output logic [24:0] ex, output logic [4:0] ev,
                                       output logic [4:0] ep, output logic [4:0] ee);
    ex = '0; ev = '0; ep = '0; ee = '0;
    for (int o = 0; o < 5; o++) begin
      if (mBusy[o]) begin
        ex[5*o + mOwner[o]] = 1'b1;
        if (rstn && v[mOwner[o]] && rdy[o]) begin
          ev[o]         = 1'b1;
          ep[mOwner[o]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 5; i++)
      if (rstn && v[i] && isHeadT(t[2*i +: 2]) && ($countones(r[5*i +: 5]) != 1) && !mLocked(i))
        ee[i] = 1'b1;
  endfunction

  // Advance the model across one clock edge; decisions use pre-edge state.
  function automatic void modelStep(input logic rstn, input logic [4:0] v,
                                    input logic [9:0] t, input logic [24:0] r,
                                    input logic [4:0] rdy);
    bit nb [5];
    int no [5];
    int np [5];
    int ow;
    int c;
    bit found;
    if (!rstn) begin
      for (int o = 0; o < 5; o++) begin
        mBusy[o] = 1'b0; mOwner[o] = 0; mPtr[o] = 0;
      end
      modelInit = 1'b1;
      return;
    end
    for (int o = 0; o < 5; o++) begin
      nb[o] = mBusy[o]; no[o] = mOwner[o]; np[o] = mPtr[o];
    end
    for (int o = 0; o < 5; o++) begin
      if (mBusy[o]) begin
        ow = mOwner[o];
        if (v[ow] && rdy[o] && (t[2*ow +: 2] == TAIL || t[2*ow +: 2] == SNGL)) begin
          nb[o] = 1'b0;
          np[o] = (ow + 1) % 5;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          c = (mPtr[o] + k) % 5;
          if (!found && mElig(c, o, v, t, r)) begin
            found = 1'b1; nb[o] = 1'b1; no[o] = c;
          end
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      mBusy[o] = nb[o]; mOwner[o] = no[o]; mPtr[o] = np[o];
    end
  endfunction

  // One clock of stimulus: drive inputs, check outputs at the falling edge,
  // then step the model at the rising edge and settle 1 unit past it.
  task automatic applyStimulus(input logic rstn, input logic [4:0] v, input logic [9:0] t,
                               input logic [24:0] r, input logic [4:0] rdy);
    logic [24:0] ex;
    logic [4:0]  ev, ep, ee;
    rst_n         = rstn;
    bus.in_valid  = v;
    bus.in_type   = t;
    bus.in_req    = r;
    bus.out_ready = rdy;
    @(negedge clk);
    modelOutputs(rstn, v, t, r, rdy, ex, ev, ep, ee);
    if (modelInit) checkOutput("xbar_sel", 32'(bus.xbar_sel), 32'(ex));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(ev));
    checkOutput("in_pop",    32'(bus.in_pop),    32'(ep));
    checkOutput("in_err",    32'(bus.in_err),    32'(ee));
    @(posedge clk);
    modelStep(rstn, v, t, r, rdy);
    #1;
  endtask

  function automatic logic [24:0] rq(input int i, input logic [4:0] q);
    return 25'(q) << (5*i);
  endfunction

  function automatic logic [9:0] tp(input int i, input logic [1:0] ty);
    return 10'(ty) << (2*i);
  endfunction

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios, then randomized traffic
  initial begin
    logic [24:0] allReq;
    logic [24:0] rr;
    logic [9:0]  tt;
    logic [4:0]  vv, rdy;
    logic        rs;

    allReq = rq(0, 5'b00001) | rq(1, 5'b00010) | rq(2, 5'b00100) |
             rq(3, 5'b01000) | rq(4, 5'b10000);

    // Reset held with every input presenting a header
    applyStimulus(1'b0, 5'h1f, 10'b1010101010, allReq, 5'h1f);
    applyStimulus(1'b0, 5'h1f, 10'b1010101010, allReq, 5'h1f);
    checkOutput("rst_xbar", 32'(bus.xbar_sel), 32'h0);
    applyStimulus(1'b1, 5'h1f, 10'b1010101010, allReq, 5'h1f);
    checkOutput("grant_after_rst", 32'(bus.xbar_sel), 32'h1041041);
    applyStimulus(1'b1, 5'h1f, 10'b1010101010, allReq, 5'h1f);
    applyStimulus(1'b1, 5'h1f, 10'b0101010101, allReq, 5'h1f);
    checkOutput("rst_pkts_done", 32'(bus.xbar_sel), 32'h0);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Single packet input 0 -> East
    applyStimulus(1'b1, 5'b00001, tp(0, HDR), rq(0, 5'b00010), 5'h1f);
    checkOutput("single_grant", 32'(bus.xbar_sel), 32'h20);
    applyStimulus(1'b1, 5'b00001, tp(0, HDR),  rq(0, 5'b00010), 5'h1f);
    applyStimulus(1'b1, 5'b00001, tp(0, BODY), rq(0, 5'b00010), 5'h1f);
    applyStimulus(1'b1, 5'b00001, tp(0, TAIL), rq(0, 5'b00010), 5'h1f);
    checkOutput("single_release", 32'(bus.xbar_sel), 32'h0);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Contention: inputs 1, 2, 4 single flits all to North
    checkOutput("contend_ptr_start", 32'(mPtr[4]), 32'h0);
    applyStimulus(1'b1, 5'b10110, tp(1, SNGL) | tp(2, SNGL) | tp(4, SNGL),
                  rq(1, 5'b10000) | rq(2, 5'b10000) | rq(4, 5'b10000), 5'h1f);
    checkOutput("contend_first", 32'(bus.xbar_sel[24:20]), 32'h2);
    for (int n = 0; n < 7; n++)
      applyStimulus(1'b1, 5'b10110, tp(1, SNGL) | tp(2, SNGL) | tp(4, SNGL),
                    rq(1, 5'b10000) | rq(2, 5'b10000) | rq(4, 5'b10000), 5'h1f);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Backpressure on East mid-packet from input 3
    applyStimulus(1'b1, 5'b01000, tp(3, HDR), rq(3, 5'b00010), 5'h1f);
    applyStimulus(1'b1, 5'b01000, tp(3, HDR), rq(3, 5'b00010), 5'h1f);
    for (int n = 0; n < 3; n++)
      applyStimulus(1'b1, 5'b01000, tp(3, BODY), rq(3, 5'b00010), 5'b11101);
    checkOutput("bp_owner_held", 32'(bus.xbar_sel[9:5]), 32'h8);
    applyStimulus(1'b1, 5'b01000, tp(3, BODY), rq(3, 5'b00010), 5'h1f);
    applyStimulus(1'b1, 5'b01000, tp(3, TAIL), rq(3, 5'b00010), 5'h1f);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Parallel: input 0 -> East and input 3 -> West together
    applyStimulus(1'b1, 5'b01001, tp(0, HDR) | tp(3, HDR),
                  rq(0, 5'b00010) | rq(3, 5'b00100), 5'h1f);
    checkOutput("parallel_grant", 32'(bus.xbar_sel), 32'h2020);
    applyStimulus(1'b1, 5'b01001, tp(0, HDR) | tp(3, HDR),
                  rq(0, 5'b00010) | rq(3, 5'b00100), 5'h1f);
    applyStimulus(1'b1, 5'b01001, tp(0, TAIL) | tp(3, TAIL),
                  rq(0, 5'b00010) | rq(3, 5'b00100), 5'h1f);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Bad multi-hot request on input 2, then corrected, then reset mid-packet
    applyStimulus(1'b1, 5'b00100, tp(2, HDR), rq(2, 5'b00110), 5'h1f);
    checkOutput("bad_req_err", 32'(bus.in_err), 32'h4);
    checkOutput("bad_req_nogrant", 32'(bus.xbar_sel), 32'h0);
    applyStimulus(1'b1, 5'b00100, tp(2, HDR), rq(2, 5'b00100), 5'h1f);
    checkOutput("fixed_req_grant", 32'(bus.xbar_sel[14:10]), 32'h4);
    applyStimulus(1'b1, 5'b00100, tp(2, HDR),  rq(2, 5'b00100), 5'h1f);
    applyStimulus(1'b1, 5'b00100, tp(2, BODY), rq(2, 5'b00100), 5'h1f);
    applyStimulus(1'b0, 5'b00100, tp(2, BODY), rq(2, 5'b00100), 5'h1f);
    checkOutput("mid_reset_idle", 32'(bus.xbar_sel), 32'h0);
    applyStimulus(1'b1, 5'h00, 10'h0, 25'h0, 5'h1f);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      rs  = ($urandom_range(99) != 0);
      vv  = 5'($urandom_range(31));
      rdy = 5'($urandom | $urandom);
      tt  = '0;
      rr  = '0;
      for (int i = 0; i < 5; i++) begin
        tt = tt | tp(i, 2'($urandom_range(3)));
        if ($urandom_range(9) < 8) rr = rr | rq(i, 5'(1 << $urandom_range(4)));
        else                       rr = rr | rq(i, 5'($urandom_range(31)));
      end
      applyStimulus(rs, vv, tt, rr, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
